// File: rtl/cpu_divide.sv
// rtl/cpu_divide.sv - radix-2 restoring integer divider; define DIV_REMAINDER_EN to drive o_remainder
module cpu_divide #(
  parameter int BW   = 32,
  parameter int LGBW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr,
  input  logic          i_signed,
  input  logic [BW-1:0] i_numerator,
  input  logic [BW-1:0] i_denominator,
  output logic          o_busy,
  output logic          o_valid,
  output logic          o_err,
  output logic [BW-1:0] o_quotient,
  output logic [BW-1:0] o_remainder,
  output logic [3:0]    o_f
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIXUP} state_t;

  state_t            state_q, state_d;
  logic [LGBW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]     prem_q, prem_d;   // partial remainder
  logic [BW-1:0]     dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [BW-1:0]     den_q, den_d;     // absolute divisor
  logic              neg_q, neg_d;     // quotient must be negated
  logic              sgn_q, sgn_d;     // signed divide, needed for overflow flag
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [BW-1:0]     quo_q, quo_d;
  logic [3:0]        f_q, f_d;
`ifdef DIV_REMAINDER_EN
  logic              rneg_q, rneg_d;   // remainder takes the numerator's sign
  logic [BW-1:0]     rem_q, rem_d;
`endif

  logic [BW:0]       shifted;
  logic [BW:0]       diff;
  logic [BW-1:0]     quo_fix;
  logic [BW-1:0]     num_abs;
  logic [BW-1:0]     den_abs;

  // Next-state, datapath step and result formation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    den_d   = den_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    err_d   = err_q;
    quo_d   = quo_q;
    f_d     = f_q;
`ifdef DIV_REMAINDER_EN
    rneg_d  = rneg_q;
    rem_d   = rem_q;
`endif
    num_abs = (i_signed && i_numerator[BW-1])   ? -i_numerator   : i_numerator;
    den_abs = (i_signed && i_denominator[BW-1]) ? -i_denominator : i_denominator;
    shifted = {prem_q, dvd_q[BW-1]};
    diff    = shifted - {1'b0, den_q};
    quo_fix = neg_q ? -dvd_q : dvd_q;

    case (state_q)
      S_IDLE: begin
        // A result still being presented blocks a new issue for that cycle
        if (i_wr && !valid_q) begin
          if (i_denominator == '0) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            quo_d   = '0;
            f_d     = 4'h0;
`ifdef DIV_REMAINDER_EN
            rem_d   = '0;
`endif
          end else begin
            neg_d   = i_signed & (i_numerator[BW-1] ^ i_denominator[BW-1]);
            sgn_d   = i_signed;
`ifdef DIV_REMAINDER_EN
            rneg_d  = i_signed & i_numerator[BW-1];
`endif
            dvd_d   = num_abs;
            den_d   = den_abs;
            prem_d  = '0;
            cnt_d   = LGBW'(BW - 1);
            busy_d  = 1'b1;
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        // No borrow means the divisor fits: keep the difference, quotient bit 1
        if (!diff[BW]) begin
          prem_d = diff[BW-1:0];
          dvd_d  = {dvd_q[BW-2:0], 1'b1};
        end else begin
          prem_d = shifted[BW-1:0];
          dvd_d  = {dvd_q[BW-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        quo_d   = quo_fix;
        // Only most-negative / -1 yields a positive signed result with the MSB set
        f_d     = {sgn_q & ~neg_q & quo_fix[BW-1], quo_fix[BW-1], 1'b0, quo_fix == '0};
        err_d   = 1'b0;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef DIV_REMAINDER_EN
        rem_d   = rneg_q ? -prem_q : prem_q;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      den_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      f_q     <= 4'h0;
`ifdef DIV_REMAINDER_EN
      rneg_q  <= 1'b0;
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      den_q   <= den_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      quo_q   <= quo_d;
      f_q     <= f_d;
`ifdef DIV_REMAINDER_EN
      rneg_q  <= rneg_d;
      rem_q   <= rem_d;
`endif
    end
  end

  assign o_busy     = busy_q;
  assign o_valid    = valid_q;
  assign o_err      = err_q;
  assign o_quotient = quo_q;
  assign o_f        = f_q;
`ifdef DIV_REMAINDER_EN
  assign o_remainder = rem_q;
`else
  assign o_remainder = '0;
`endif

endmodule

// File: tb/tb_cpu_divide.sv
// tb/tb_cpu_divide.sv - randomized self-checking bench for cpu_divide
module tb_cpu_divide;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] num = '0;
  logic [31:0] den = '0;
  logic        busy, valid, err;
  logic [31:0] quo, rem;
  logic [3:0]  f;

  int checks = 0;
  int failures = 0;

  cpu_divide #(.BW(32), .LGBW(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_signed(sgn),
    .i_numerator(num), .i_denominator(den),
    .o_busy(busy), .o_valid(valid), .o_err(err),
    .o_quotient(quo), .o_remainder(rem), .o_f(f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic
  task automatic ref_div(input logic [31:0] n, input logic [31:0] d, input logic s,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic e, output logic [3:0] fl);
    longint a, b, q64, r64;
    if (d == 0) begin
      q = 0; r = 0; e = 1'b1; fl = 4'h0;
    end else begin
      if (s) begin a = longint'($signed(n)); b = longint'($signed(d)); end
      else   begin a = longint'({32'b0, n}); b = longint'({32'b0, d}); end
      q64 = a / b;
      r64 = a % b;
      q = q64[31:0];
      r = r64[31:0];
      e = 1'b0;
      fl = {s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF, q[31], 1'b0, q == 0};
    end
`ifndef DIV_REMAINDER_EN
    r = 0;
`endif
  endtask

  // Timing-level model: cycle numbers of busy window, result edge, next free edge
  int cyc = 0;
  int b_lo = 1, b_hi = 0, v_at = -1, free_at = 0;
  bit started = 0, f_known = 0;
  logic [31:0] p_q, p_r, e_q = 0, e_r = 0;
  logic        p_e, e_e = 0;
  logic [3:0]  p_f, e_f = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      started = 1; b_lo = 1; b_hi = 0; v_at = -1; free_at = 0;
      e_q = 0; e_r = 0; e_e = 0; f_known = 0;
    end else begin
      if (wr && cyc >= free_at) begin
        ref_div(num, den, sgn, p_q, p_r, p_e, p_f);
        if (den == 0) begin
          v_at = cyc; free_at = cyc + 2;
        end else begin
          b_lo = cyc; b_hi = cyc + 32; v_at = cyc + 33; free_at = cyc + 35;
        end
      end
      if (cyc == v_at) begin
        e_q = p_q; e_r = p_r; e_e = p_e; e_f = p_f; f_known = 1;
      end
    end
  end

  // Compare DUT against model every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("busy", 64'(busy), 64'(cyc >= b_lo && cyc <= b_hi));
      chk("valid", 64'(valid), 64'(cyc == v_at));
      chk("quotient", 64'(quo), 64'(e_q));
      chk("remainder", 64'(rem), 64'(e_r));
      chk("err", 64'(err), 64'(e_e));
      if (f_known) chk("flags", 64'(f), 64'(e_f));
    end
  end

  task automatic issue(input logic [31:0] n, input logic [31:0] d, input logic s);
    @(posedge clk); #1;
    wr = 1'b1; num = n; den = d; sgn = s;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 60);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom % 256;
      default: return $urandom;
    endcase
  endfunction

  int lat, pulses;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_quotient", 64'(quo), 64'h0);

    issue(100, 7, 1'b0);
    wait_valid(lat);
    chk("lat_100_7", 64'(lat), 64'd34);
    chk("q_100_7", 64'(quo), 64'd14);
    chk("f_100_7", 64'(f), 64'h0);
`ifdef DIV_REMAINDER_EN
    chk("r_100_7", 64'(rem), 64'd2);
`endif

    issue(32'hFFFF_FF9C, 7, 1'b1);
    wait_valid(lat);
    chk("q_m100_7", 64'(quo), 64'hFFFF_FFF2);
    chk("f_m100_7", 64'(f), 64'h4);
`ifdef DIV_REMAINDER_EN
    chk("r_m100_7", 64'(rem), 64'hFFFF_FFFE);
`endif

    issue(5, 0, 1'b0);
    wait_valid(lat);
    chk("lat_div0", 64'(lat), 64'd1);
    chk("err_div0", 64'(err), 64'h1);
    chk("q_div0", 64'(quo), 64'h0);
    issue(9, 3, 1'b0);
    wait_valid(lat);
    chk("q_9_3", 64'(quo), 64'd3);
    chk("err_9_3", 64'(err), 64'h0);

    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_valid(lat);
    chk("q_ovf", 64'(quo), 64'h8000_0000);
    chk("f_ovf", 64'(f), 64'hC);
    issue(32'hFFFF_FFFF, 1, 1'b0);
    wait_valid(lat);
    chk("q_umax", 64'(quo), 64'hFFFF_FFFF);
    chk("f_umax", 64'(f), 64'h4);

    issue(1000, 10, 1'b0);
    repeat (9) @(posedge clk);
    #1 wr = 1'b1; num = 50; den = 5;
    @(posedge clk); #1 wr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        chk("q_1000_10", 64'(quo), 64'd100);
      end
    end
    chk("pulses_busy_wr", 64'(pulses), 64'd1);

    issue(1000, 10, 1'b0);
    repeat (13) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_rst", 64'(busy), 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("pulses_after_rst", 64'(pulses), 64'd0);
    issue(0, 9, 1'b0);
    wait_valid(lat);
    chk("lat_0_9", 64'(lat), 64'd34);
    chk("q_0_9", 64'(quo), 64'h0);
    chk("f_0_9", 64'(f), 64'h1);

    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      wr = ($urandom % 4 == 0);
      sgn = $urandom % 2;
      num = rand_op();
      den = rand_op();
      rst_n = ($urandom % 1500 != 0);
    end
    @(posedge clk); #1 wr = 1'b0; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
